// File: rtl/param_serdes.sv
// param_serdes: parametrised full-duplex serialiser/deserialiser (valid/ready TX, framed RX with error pulses).
// Optional macro PARITY_EN: TX appends and RX checks one even-parity bit after the data word.
module param_serdes #(
    parameter int WIDTH     = 32,
    parameter bit MSB_FIRST = 1'b1,
    parameter int FRAME_GAP = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] p_in,
    input  logic             p_in_valid,
    output logic             p_in_ready,
    output logic             s_out,
    output logic             s_out_frame,
    input  logic             s_in,
    input  logic             s_in_frame,
    output logic [WIDTH-1:0] p_out,
    output logic             p_valid,
    output logic             p_err
);
`ifdef PARITY_EN
    localparam int PAR = 1;
`else
    localparam int PAR = 0;
`endif
    localparam int FLEN = WIDTH + PAR;
    localparam int TCW  = $clog2((FLEN > FRAME_GAP ? FLEN : FRAME_GAP) + 1);
    localparam int RCW  = $clog2(WIDTH + 2);
    localparam logic [TCW-1:0] TX_LAST  = TCW'(FLEN - 1);
    localparam logic [TCW-1:0] GAP_LAST = TCW'(FRAME_GAP > 0 ? FRAME_GAP - 1 : 0);
    localparam logic [RCW-1:0] RX_LAST  = RCW'(FLEN - 1);

    typedef enum logic [1:0] {IDLE, SHIFT, GAP} tx_state_t;

    tx_state_t        state, state_n;
    logic [FLEN-1:0]  tx_sr, tx_sr_n, frame_vec;
    logic [TCW-1:0]   tx_cnt, tx_cnt_n;
    logic [WIDTH-1:0] ordered;
    logic             ready_n, frame_n;

    // The shift register always emits its top bit, so the word is pre-ordered for the chosen bit order.
    always_comb begin
        for (int i = 0; i < WIDTH; i++) ordered[i] = MSB_FIRST ? p_in[i] : p_in[WIDTH-1-i];
    end

`ifdef PARITY_EN
    assign frame_vec = {ordered, ^p_in};
`else
    assign frame_vec = ordered;
`endif

    // Zeros shift in behind the frame, so s_out is already 0 once the frame has gone out.
    assign s_out = tx_sr[FLEN-1];

    always_comb begin
        state_n  = state;
        tx_sr_n  = tx_sr;
        tx_cnt_n = tx_cnt;
        ready_n  = p_in_ready;
        frame_n  = s_out_frame;
        case (state)
            IDLE: begin
                ready_n = 1'b1;
                if (p_in_valid && p_in_ready) begin
                    state_n  = SHIFT;
                    tx_sr_n  = frame_vec;
                    tx_cnt_n = '0;
                    ready_n  = 1'b0;
                    frame_n  = 1'b1;
                end
            end
            SHIFT: begin
                tx_sr_n  = tx_sr << 1;
                tx_cnt_n = tx_cnt + 1'b1;
                if (tx_cnt == TX_LAST) begin
                    tx_cnt_n = '0;
                    frame_n  = 1'b0;
                    state_n  = (FRAME_GAP == 0) ? IDLE : GAP;
                    ready_n  = (FRAME_GAP == 0);
                end
            end
            GAP: begin
                tx_cnt_n = tx_cnt + 1'b1;
                if (tx_cnt == GAP_LAST) begin
                    tx_cnt_n = '0;
                    state_n  = IDLE;
                    ready_n  = 1'b1;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            tx_sr       <= '0;
            tx_cnt      <= '0;
            p_in_ready  <= 1'b0;
            s_out_frame <= 1'b0;
        end else begin
            state       <= state_n;
            tx_sr       <= tx_sr_n;
            tx_cnt      <= tx_cnt_n;
            p_in_ready  <= ready_n;
            s_out_frame <= frame_n;
        end
    end

    logic [RCW-1:0]   rx_cnt;
    logic [WIDTH-1:0] rx_sr, rx_shift, rx_word;
    logic             rx_data, rx_good;

    assign rx_shift = MSB_FIRST ? {rx_sr[WIDTH-2:0], s_in} : {s_in, rx_sr[WIDTH-1:1]};

`ifdef PARITY_EN
    // The final frame bit is parity: it is checked, never shifted into the word.
    assign rx_data = (rx_cnt != RX_LAST);
    assign rx_word = rx_sr;
    assign rx_good = ((^rx_sr) == s_in);
`else
    assign rx_data = 1'b1;
    assign rx_word = rx_shift;
    assign rx_good = 1'b1;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rx_cnt  <= '0;
            rx_sr   <= '0;
            p_out   <= '0;
            p_valid <= 1'b0;
            p_err   <= 1'b0;
        end else begin
            p_valid <= 1'b0;
            p_err   <= 1'b0;
            if (s_in_frame) begin
                if (rx_data) rx_sr <= rx_shift;
                if (rx_cnt == RX_LAST) begin
                    rx_cnt <= '0;
                    if (rx_good) begin
                        p_out   <= rx_word;
                        p_valid <= 1'b1;
                    end else begin
                        p_err <= 1'b1;
                    end
                end else begin
                    rx_cnt <= rx_cnt + 1'b1;
                end
            end else if (rx_cnt != '0) begin
                rx_cnt <= '0;
                p_err  <= 1'b1;
            end
        end
    end
endmodule
